icache_linefill_ctrl: RTL



---
 rtl/icache_linefill_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/icache_linefill_ctrl.sv
// Icache linefill return path: assembles downstream beats into a line and writes the dataram.
// Optional protocol checking (rxdat_last, txnid stability) under ICACHE_LINEFILL_PROTO_CHK_EN.
module icache_linefill_ctrl #(
    parameter int MSHR_ENTRY_NUM = 8,
    parameter int TXNID_WIDTH    = 3,
    parameter int BEAT_WIDTH     = 128,
    parameter int BEATS_PER_LINE = 4,
    parameter int INDEX_WIDTH    = 7,
    parameter int WAY_NUM        = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       rxdat_vld,
    output logic                                       rxdat_rdy,
    input  logic [BEAT_WIDTH-1:0]                      rxdat_data,
    input  logic [TXNID_WIDTH-1:0]                     rxdat_txnid,
    input  logic                                       rxdat_last,
    input  logic [MSHR_ENTRY_NUM*INDEX_WIDTH-1:0]      v_entry_index,
    input  logic [MSHR_ENTRY_NUM*$clog2(WAY_NUM)-1:0]  v_entry_way,
    output logic                                       dataram_wr_vld,
    input  logic                                       dataram_wr_rdy,
    output logic [INDEX_WIDTH-1:0]                     dataram_wr_index,
    output logic [$clog2(WAY_NUM)-1:0]                 dataram_wr_way,
    output logic [BEAT_WIDTH*BEATS_PER_LINE-1:0]       dataram_wr_data,
    output logic [MSHR_ENTRY_NUM-1:0]                  v_linefill_done,
    output logic                                       linefill_err
);

    localparam int WAY_W  = $clog2(WAY_NUM);
    localparam int CNT_W  = $clog2(BEATS_PER_LINE) + 1;
    localparam int LINE_W = BEAT_WIDTH * BEATS_PER_LINE;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS_PER_LINE - 1);
    localparam logic [TXNID_WIDTH:0] ENTRY_LIM = (TXNID_WIDTH + 1)'(MSHR_ENTRY_NUM);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cur_slot;
    logic [LINE_W-1:0]        line_buf;
    logic [TXNID_WIDTH-1:0]   txnid_q;
    logic [INDEX_WIDTH-1:0]   index_q;
    logic [INDEX_WIDTH-1:0]   lookup_index;
    logic [WAY_W-1:0]         way_q;
    logic [WAY_W-1:0]         lookup_way;
    logic                     err_q;
    logic                     accept;
    logic                     first_beat;
    logic                     txnid_oor;
    logic                     txnid_bad;
    logic                     last_bad;
    logic                     slot_last;
    logic                     beat_keep;
    logic                     err_set;

    assign accept     = rxdat_vld && rxdat_rdy;
    assign first_beat = accept && (state == IDLE);
    assign cur_slot   = (state == IDLE) ? '0 : cnt;
    assign slot_last  = (cur_slot == LAST_SLOT);
    assign txnid_oor  = {1'b0, rxdat_txnid} >= ENTRY_LIM;

`ifdef ICACHE_LINEFILL_PROTO_CHK_EN
    // A foreign txnid mid-line is consumed but never stored or counted.
    assign txnid_bad = (state == COLLECT) && (rxdat_txnid != txnid_q);
    assign last_bad  = (rxdat_last != slot_last);
`else
    logic unused_last;
    assign unused_last = rxdat_last;
    assign txnid_bad   = 1'b0;
    assign last_bad    = 1'b0;
`endif

    assign beat_keep = accept && !txnid_bad;
    assign err_set   = (first_beat && txnid_oor)
                     || (accept && txnid_bad)
                     || (beat_keep && last_bad);

    always_comb begin
        lookup_index = '0;
        lookup_way   = '0;
        for (int i = 0; i < MSHR_ENTRY_NUM; i++) begin
            if ({1'b0, rxdat_txnid} == (TXNID_WIDTH + 1)'(i)) begin
                lookup_index = v_entry_index[i*INDEX_WIDTH +: INDEX_WIDTH];
                lookup_way   = v_entry_way[i*WAY_W +: WAY_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (BEATS_PER_LINE == 1) ? WRITE : COLLECT;
                end
            end
            COLLECT: begin
                if (beat_keep && slot_last) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (dataram_wr_rdy) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            line_buf <= '0;
            txnid_q  <= '0;
            index_q  <= '0;
            way_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            // Index/way are captured once per line; later vector changes are ignored.
            if (first_beat) begin
                txnid_q <= rxdat_txnid;
                index_q <= lookup_index;
                way_q   <= lookup_way;
            end
            if (beat_keep) begin
                for (int k = 0; k < BEATS_PER_LINE; k++) begin
                    if (cur_slot == CNT_W'(k)) begin
                        line_buf[k*BEAT_WIDTH +: BEAT_WIDTH] <= rxdat_data;
                    end
                end
                if ((state == COLLECT) && slot_last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cur_slot + 1'b1;
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rxdat_rdy        = (state == IDLE) || (state == COLLECT);
        dataram_wr_vld   = (state == WRITE);
        dataram_wr_index = index_q;
        dataram_wr_way   = way_q;
        dataram_wr_data  = line_buf;
        linefill_err     = err_q;
        v_linefill_done  = '0;
        for (int i = 0; i < MSHR_ENTRY_NUM; i++) begin
            v_linefill_done[i] = (state == DONE)
                && ({1'b0, txnid_q} == (TXNID_WIDTH + 1)'(i));
        end
    end

endmodule
